// File: rtl/ps2_keyb_evfifo_pkg.sv
// Shared definitions for the PS/2 keyboard event FIFO: default register
// addresses, status/control bit positions and the packed key-event type.
package ps2_keyb_pkg;

    localparam logic [7:0] SCANCODE_ADDR = 8'h04;
    localparam logic [7:0] KBSTATUS_ADDR = 8'h05;
    localparam logic [7:0] KBCTRL_ADDR   = 8'h0B;

    localparam int ST_BSY  = 7;
    localparam int ST_OVF  = 6;
    localparam int ST_FULL = 5;
    localparam int ST_IEN  = 4;
    localparam int ST_ERR  = 3;
    localparam int ST_RLS  = 2;
    localparam int ST_EXT  = 1;
    localparam int ST_NE   = 0;

    localparam int CTRL_FLUSH = 0;
    localparam int CTRL_IEN   = 1;

    typedef struct packed {
        logic       ext;
        logic       rls;
        logic [7:0] code;
    } kb_event_t;

endpackage

// File: rtl/ps2_keyb_evfifo_if.sv
// ZX-Uno register bus as seen by the keyboard block.
// Strobes are levels: regrd/regwr are high while the CPU accesses zxuno_addr;
// the device answers combinationally on *_dout with active-low output enables.
interface ps2_keyb_evfifo_if;
    logic [7:0] zxuno_addr;
    logic       zxuno_regrd;
    logic       zxuno_regwr;
    logic [7:0] din;
    logic [7:0] scancode_dout;
    logic       oe_n_scancode;
    logic [7:0] kbstatus_dout;
    logic       oe_n_kbstatus;

    modport master (
        output zxuno_addr, zxuno_regrd, zxuno_regwr, din,
        input  scancode_dout, oe_n_scancode, kbstatus_dout, oe_n_kbstatus
    );

    modport slave (
        input  zxuno_addr, zxuno_regrd, zxuno_regwr, din,
        output scancode_dout, oe_n_scancode, kbstatus_dout, oe_n_kbstatus
    );
endinterface

// File: rtl/ps2_keyb_evfifo_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO only succeeds when a
// pop happens in the same cycle, and a pop from an empty FIFO is ignored.
module ps2_event_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    input  logic [WIDTH-1:0]      data_i,
    output logic [WIDTH-1:0]      head_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   count_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_CNT);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/ps2_keyb_evfifo.sv
// Keyboard front end: buffers decoded PS/2 events for the ZX-Uno CPU, reports
// status/overflow, raises a level IRQ and forwards host commands to the keyboard.
// Optional TYPEMATIC_FILTER_EN drops auto-repeated make codes.
module ps2_keyb_evfifo
    import ps2_keyb_pkg::*;
#(
    parameter int         DEPTH_LOG2 = 4,
    parameter logic [7:0] SCANCODE   = SCANCODE_ADDR,
    parameter logic [7:0] KBSTATUS   = KBSTATUS_ADDR,
    parameter logic [7:0] KBCTRL     = KBCTRL_ADDR
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    scan_valid,
    input  logic [7:0]              scancode,
    input  logic                    extended,
    input  logic                    released,
    input  logic                    host_busy,
    input  logic                    host_error,
    ps2_keyb_evfifo_if.slave        bus,
    output logic [7:0]              host_data,
    output logic                    host_load,
    output logic                    kb_irq_n
);
    logic rd_sc, rd_st, wr_sc, wr_ctl;
    logic rd_sc_q, rd_st_q, wr_sc_q, wr_ctl_q;
    logic pop, push, flush, keep_ev, ctl_rise, sc_rise, ovf_set, ovf_clr;
    logic ovf_q, ovf_d, irq_en_q, irq_en_d, host_load_q, kb_irq_n_q;
    logic [7:0] host_data_q, host_data_d, status;
    kb_event_t new_ev, head_ev;
    logic fifo_empty, fifo_full;
    logic [DEPTH_LOG2:0] fifo_count;

    assign rd_sc  = bus.zxuno_regrd && (bus.zxuno_addr == SCANCODE);
    assign rd_st  = bus.zxuno_regrd && (bus.zxuno_addr == KBSTATUS);
    assign wr_sc  = bus.zxuno_regwr && (bus.zxuno_addr == SCANCODE);
    assign wr_ctl = bus.zxuno_regwr && (bus.zxuno_addr == KBCTRL);

    // Reads act on the falling edge so long strobes still count once.
    assign pop      = rd_sc_q & ~rd_sc;
    assign ovf_clr  = rd_st_q & ~rd_st;
    assign sc_rise  = wr_sc & ~wr_sc_q;
    assign ctl_rise = wr_ctl & ~wr_ctl_q;
    assign flush    = ctl_rise & bus.din[CTRL_FLUSH];
    assign push     = scan_valid & keep_ev & ~flush;
    assign ovf_set  = push & fifo_full & ~pop;

    assign new_ev = '{ext: extended, rls: released, code: scancode};

`ifdef TYPEMATIC_FILTER_EN
    logic       lm_valid_q, lm_valid_d, lm_ext_q, lm_ext_d, lm_match;
    logic [7:0] lm_code_q, lm_code_d;

    assign lm_match = lm_valid_q && (lm_ext_q == extended) && (lm_code_q == scancode);

    always_comb begin
        keep_ev    = 1'b1;
        lm_valid_d = lm_valid_q;
        lm_ext_d   = lm_ext_q;
        lm_code_d  = lm_code_q;
        if (flush) begin
            lm_valid_d = 1'b0;
        end else if (scan_valid) begin
            if (!released) begin
                if (lm_match) begin
                    keep_ev = 1'b0;
                end else begin
                    lm_valid_d = 1'b1;
                    lm_ext_d   = extended;
                    lm_code_d  = scancode;
                end
            end else if (lm_match) begin
                lm_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lm_valid_q <= 1'b0;
            lm_ext_q   <= 1'b0;
            lm_code_q  <= 8'h00;
        end else begin
            lm_valid_q <= lm_valid_d;
            lm_ext_q   <= lm_ext_d;
            lm_code_q  <= lm_code_d;
        end
    end
`else
    assign keep_ev = 1'b1;
`endif

    ps2_event_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      ($bits(kb_event_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .data_i  (new_ev),
        .head_o  (head_ev),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    // Overflow set beats a same-cycle status-read clear; flush discards both.
    always_comb begin
        ovf_d = ovf_q;
        if (flush) begin
            ovf_d = 1'b0;
        end else if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        irq_en_d    = ctl_rise ? bus.din[CTRL_IEN] : irq_en_q;
        host_data_d = (sc_rise && !host_busy) ? bus.din : host_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_sc_q     <= 1'b0;
            rd_st_q     <= 1'b0;
            wr_sc_q     <= 1'b0;
            wr_ctl_q    <= 1'b0;
            ovf_q       <= 1'b0;
            irq_en_q    <= 1'b0;
            host_data_q <= 8'h00;
            host_load_q <= 1'b0;
            kb_irq_n_q  <= 1'b1;
        end else begin
            rd_sc_q     <= rd_sc;
            rd_st_q     <= rd_st;
            wr_sc_q     <= wr_sc;
            wr_ctl_q    <= wr_ctl;
            ovf_q       <= ovf_d;
            irq_en_q    <= irq_en_d;
            host_data_q <= host_data_d;
            host_load_q <= sc_rise & ~host_busy;
            kb_irq_n_q  <= ~(irq_en_q & ~fifo_empty);
        end
    end

    always_comb begin
        status          = 8'h00;
        status[ST_BSY]  = host_busy;
        status[ST_OVF]  = ovf_q;
        status[ST_FULL] = fifo_full;
        status[ST_IEN]  = irq_en_q;
        status[ST_ERR]  = host_error;
        status[ST_RLS]  = head_ev.rls & ~fifo_empty;
        status[ST_EXT]  = head_ev.ext & ~fifo_empty;
        status[ST_NE]   = (fifo_count != '0);
    end

    assign bus.scancode_dout = fifo_empty ? 8'h00 : head_ev.code;
    assign bus.kbstatus_dout = status;
    assign bus.oe_n_scancode = ~rd_sc;
    assign bus.oe_n_kbstatus = ~rd_st;

    assign host_data = host_data_q;
    assign host_load = host_load_q;
    assign kb_irq_n  = kb_irq_n_q;
endmodule

// File: doc/ps2_keyb_evfifo.md
Name: ps2_keyb_evfifo

Overview:
Parametrised successor to the single-register keyboard front end. Sits between the PS/2 receive decoder (scancode plus flags, new-key pulse) and the ZX-Uno register bus. Buffers decoded key events in a depth-configurable FIFO so the CPU cannot lose keystrokes. Adds overflow status, a flush/IRQ control register, a level interrupt and host-to-keyboard command arbitration.

Parameters:
DEPTH_LOG2, 4, FIFO holds 2**DEPTH_LOG2 events (1..6 legal)
SCANCODE, 8'h04, register address: event data read / host command write
KBSTATUS, 8'h05, register address: status read
KBCTRL, 8'h0B, register address: control write

Ports:
clk  in  1  system clock; the only clock
rst  in  1  reset, synchronous, active-high
scan_valid  in  1  one-cycle pulse, new decoded event
scancode  in  8  event code
extended  in  1  E0 prefix seen
released  in  1  F0 prefix seen
host_busy  in  1  host-to-keyboard transmitter busy
host_error  in  1  host-to-keyboard transmit error
zxuno_addr  in  8  register address
zxuno_regrd  in  1  read strobe (level, may last several cycles)
zxuno_regwr  in  1  write strobe (level)
din  in  8  CPU write data
scancode_dout  out  8  head event code
oe_n_scancode  out  1  low while SCANCODE is read
kbstatus_dout  out  8  status byte
oe_n_kbstatus  out  1  low while KBSTATUS is read
host_data  out  8  command byte to transmitter
host_load  out  1  one-cycle load pulse to transmitter
kb_irq_n  out  1  active-low interrupt

Behaviour:
- Reset: FIFO empty; OVF=0; irq_en=0; host_data=8'h00; host_load=0; kb_irq_n=1; filter state cleared.
- Entry = {ext, rls, code}, 10 bits.
- Push: on scan_valid, the entry is written at the tail. It is visible at the head on the next cycle if the FIFO was empty.
- Outputs are combinational from the head: scancode_dout = head code, or 8'h00 when empty.
- kbstatus_dout = {host_busy, OVF, FULL, irq_en, host_error, head_rls, head_ext, NE}. head_rls and head_ext are 0 when empty.
- oe_n_* = ~(zxuno_addr==reg && zxuno_regrd).
- Pop: occurs in the cycle after the SCANCODE read strobe deasserts (falling edge of the read). One pop per access regardless of strobe length. No pop when empty.
- OVF is sticky. It clears in the cycle after a KBSTATUS read deasserts. If a set and a clear occur in the same cycle, set wins.
- Full + push, no pop: event dropped, OVF<=1, contents unchanged.
- Full + push + pop in the same cycle: both occur; count unchanged; OVF not set.
- Push + pop otherwise: both occur; count unchanged.
- Pointers wrap modulo 2**DEPTH_LOG2. Count is DEPTH_LOG2+1 bits.
- SCANCODE write, first cycle of regwr (rising edge only):
  - host_busy=0: host_data<=din and host_load=1 for exactly one cycle.
  - host_busy=1: write discarded, no pulse.
- KBCTRL write, rising edge of regwr:
  - din[0]=1 flushes the FIFO (pointers and count zeroed) and clears OVF. A push in the same cycle is discarded.
  - irq_en<=din[1].
  - din[7:2] ignored.
- kb_irq_n is registered: kb_irq_n <= ~(irq_en & NE), so it lags state by one cycle.
- rst mid-access: the read/write edge detectors clear, so no spurious pop or load follows reset.

Optional Feature:
TYPEMATIC_FILTER_EN:
- Defined: a last_make register {valid, ext, code} is kept.
  - A make whose {ext, code} equals a valid last_make is dropped (no push, no OVF).
  - A different make is pushed and becomes last_make.
  - A break matching last_make is pushed and clears valid.
  - Other breaks are pushed with last_make unchanged.
  - Flush and rst clear valid.
- Undefined: every scan_valid event is pushed; no filter state exists.

Decomposition:
- Package ps2_keyb_pkg holds:
  - default register addresses;
  - KBSTATUS bit indices (BSY=7, OVF=6, FULL=5, IEN=4, ERR=3, RLS=2, EXT=1, NE=0);
  - KBCTRL bit indices (FLUSH=0, IEN=1);
  - a 10-bit packed event typedef.
- One sub-module, ps2_event_fifo: synchronous FIFO parametrised by DEPTH_LOG2 and width, with push/pop/flush inputs and empty/full/count outputs.

Test Plan:
- Push codes 1C, 32, 21 (no flags); read SCANCODE three times, strobe held 3 cycles each -> returns 1C, 32, 21, one pop per read; NE=0 afterwards, scancode_dout=00.
- DEPTH_LOG2=4: push 17 events without reads -> FULL=1, OVF=1, first 16 retained in order; a KBSTATUS read clears OVF after strobe deassertion.
- FIFO full; push in the same cycle as a pop-triggering read end -> count stays 16, new event at tail, OVF stays 0.
- Write KBCTRL=8'h02 then push 5A -> kb_irq_n low one cycle after NE; write KBCTRL=8'h01 -> FIFO empty, OVF=0, kb_irq_n high next cycle.
- SCANCODE write FF with host_busy=0 -> host_data=FF, host_load high exactly 1 cycle over a 4-cycle regwr; repeat with host_busy=1 -> no pulse.
- With TYPEMATIC_FILTER_EN: make 1C x4, break 1C (rls=1), make 1C -> FIFO holds {1C make, 1C break, 1C make}. Without the macro -> all 6 events are pushed.
